// File: rtl/cpu_core_pkg.sv
// cpu_core shared definitions: opcodes, FSM states, ALU selects, flag bits.
// Shared by cpu_core_param and cpu_alu_param.
package cpu_core_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_SHR  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_SHRI = 4'b0110;
  localparam logic [3:0] OP_SUBI = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JZ   = 4'b1001;
  localparam logic [3:0] OP_JC   = 4'b1010;
  localparam logic [3:0] OP_JN   = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int F_CF = 2;
  localparam int F_ZF = 1;
  localparam int F_SF = 0;

  typedef enum logic [1:0] {
    S_HALT,
    S_FETCH,
    S_EXEC
  } state_t;

  // Matches the low two opcode bits of the ALU group.
  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_AND,
    ALU_SHR,
    ALU_SUB
  } alu_op_t;

endpackage

// File: rtl/cpu_alu_param.sv
// cpu_core combinational ALU: ADD/AND/SHR/SUB, mod 2^DATA_W.
// Produces result plus carry/borrow, zero and sign flags.
module cpu_alu_param
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              cf,
  output logic              zf,
  output logic              sf
);

  localparam logic [DATA_W-1:0] W_LIM = DATA_W'(DATA_W);

  always_comb begin
    result = '0;
    cf     = 1'b0;
    unique case (op)
      ALU_ADD: {cf, result} = {1'b0, a} + {1'b0, b};
      ALU_AND: result = a & b;
      ALU_SHR: result = (b >= W_LIM) ? '0 : (a >> b);
      ALU_SUB: begin
        result = a - b;
        cf     = (a < b);
      end
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[DATA_W-1];
  end

endmodule

// File: rtl/cpu_core_param.sv
// cpu_core_param: multicycle HALT/FETCH/EXEC core with program store.
// Optional retired-instruction counter under `CPU_INSTR_CNT_EN.
module cpu_core_param
  import cpu_core_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NREG     = 8,
  parameter int PM_DEPTH = 16,
  localparam int RA_W    = $clog2(NREG),
  localparam int PC_W    = $clog2(PM_DEPTH),
  localparam int INSTR_W = 4 + RA_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               start,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         flags,
  input  logic [RA_W-1:0]    dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [31:0]        instr_cnt
);

  state_t               state;
  logic [INSTR_W-1:0]   ir;
  logic [INSTR_W-1:0]   pm   [PM_DEPTH];
  logic [DATA_W-1:0]    regs [NREG];

  logic [3:0]           op;
  logic [RA_W-1:0]      rd;
  logic [DATA_W-1:0]    imm;
  logic [DATA_W-1:0]    opb;
  logic [DATA_W-1:0]    res;
  logic                 cf, zf, sf;
  logic                 is_alu, is_halt, take;
  logic [PC_W-1:0]      pc_nxt;

  assign op  = ir[INSTR_W-1 -: 4];
  assign rd  = ir[INSTR_W-5 -: RA_W];
  assign imm = ir[DATA_W-1:0];

  assign is_alu  = ~op[3];
  assign is_halt = (op == OP_HALT);
  assign opb     = op[2] ? imm : regs[imm[RA_W-1:0]];

  cpu_alu_param #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op_t'(op[1:0])),
    .a      (regs[rd]),
    .b      (opb),
    .result (res),
    .cf     (cf),
    .zf     (zf),
    .sf     (sf)
  );

  always_comb begin
    pc_nxt = pc + PC_W'(1);
    take   = 1'b0;
    unique case (op)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = flags[F_ZF];
      OP_JC:   take = flags[F_CF];
      OP_JN:   take = flags[F_SF];
      default: take = 1'b0;
    endcase
    unique case (1'b1)
      take:    pc_nxt = imm[PC_W-1:0];
      is_halt: pc_nxt = pc;
      default: ;
    endcase
  end

  // Program store has no reset; host writes only while halted.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_HALT)
      pm[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_HALT;
      pc    <= '0;
      flags <= '0;
      ir    <= '0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      unique case (state)
        S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        S_FETCH: begin
          ir    <= pm[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          pc    <= pc_nxt;
          state <= is_halt ? S_HALT : S_FETCH;
          if (is_alu) begin
            regs[rd] <= res;
            flags    <= {cf, zf, sf};
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign halted    = (state == S_HALT);
  assign dbg_rdata = regs[dbg_raddr];

`ifdef CPU_INSTR_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (state == S_EXEC)
      cnt <= cnt + 32'd1;
  end

  assign instr_cnt = cnt;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param at DATA_W=8, NREG=8, PM_DEPTH=16.
// Hand-computed expectations; instr_cnt checks follow CPU_INSTR_CNT_EN.
module tb_cpu_core_param;

  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] AND_ = 4'h1;
  localparam logic [3:0] SUB  = 4'h3;
  localparam logic [3:0] ADDI = 4'h4;
  localparam logic [3:0] SHRI = 4'h6;
  localparam logic [3:0] SUBI = 4'h7;
  localparam logic [3:0] JZ   = 4'h9;
  localparam logic [3:0] JC   = 4'hA;
  localparam logic [3:0] JN   = 4'hB;
  localparam logic [3:0] NOP  = 4'hC;
  localparam logic [3:0] HLT  = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [14:0] prog_wdata;
  logic        start;
  logic        halted;
  logic [3:0]  pc;
  logic [2:0]  flags;
  logic [2:0]  dbg_raddr;
  logic [7:0]  dbg_rdata;
  logic [31:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic [7:0] v;

  cpu_core_param #(.DATA_W(8), .NREG(8), .PM_DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .halted     (halted),
    .pc         (pc),
    .flags      (flags),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] ins(input logic [3:0] o,
                                      input logic [2:0] r,
                                      input logic [7:0] lo);
    return {o, r, lo};
  endfunction

  task automatic load(input logic [3:0] a, input logic [14:0] w);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = w;
    tick();
    prog_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic peek(input logic [2:0] r, output logic [7:0] val);
    dbg_raddr = r;
    #1;
    val = dbg_rdata;
  endtask

  // Pulses start (with whatever prog_we the caller set) and waits for HALT.
  task automatic run(input int bound, output int n);
    start = 1'b1;
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    n = 0;
    while (!halted && n < bound) begin
      tick();
      n++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef CPU_INSTR_CNT_EN
    return n;
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  initial begin
    rst_n      = 1'b1;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    start      = 1'b0;
    dbg_raddr  = '0;
    tick();
    do_reset();

    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_pc", {28'd0, pc}, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);
    chk("rst_cnt", instr_cnt, 32'd0);

    load(4'd0, ins(ADDI, 3'd1, 8'd200));
    load(4'd1, ins(ADDI, 3'd1, 8'd100));
    load(4'd2, ins(HLT, 3'd0, 8'd0));
    run(50, cyc);
    chk("add_cycles", cyc, 32'd6);
    peek(3'd1, v);
    chk("add_r1", {24'd0, v}, 32'd44);
    chk("add_flags", {29'd0, flags}, 32'b100);
    chk("add_pc", {28'd0, pc}, 32'd2);
    chk("add_cnt", instr_cnt, cnt_exp(3));

    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    do_reset();
    chk("mid_halted", {31'd0, halted}, 32'd1);
    chk("mid_pc", {28'd0, pc}, 32'd0);
    chk("mid_flags", {29'd0, flags}, 32'd0);
    chk("mid_cnt", instr_cnt, 32'd0);
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), v);
      chk($sformatf("mid_r%0d", i), {24'd0, v}, 32'd0);
    end
    run(50, cyc);
    peek(3'd1, v);
    chk("retain_r1", {24'd0, v}, 32'd44);
    chk("retain_flags", {29'd0, flags}, 32'b100);

    do_reset();
    load(4'd0, ins(ADDI, 3'd2, 8'd5));
    load(4'd1, ins(SUBI, 3'd2, 8'd5));
    load(4'd2, ins(JZ, 3'd0, 8'd5));
    load(4'd3, ins(ADDI, 3'd2, 8'd1));
    load(4'd4, ins(HLT, 3'd0, 8'd0));
    load(4'd5, ins(HLT, 3'd0, 8'd0));
    run(50, cyc);
    peek(3'd2, v);
    chk("jz_r2", {24'd0, v}, 32'd0);
    chk("jz_flags", {29'd0, flags}, 32'b010);
    chk("jz_pc", {28'd0, pc}, 32'd5);
    chk("jz_cnt", instr_cnt, cnt_exp(4));

    do_reset();
    load(4'd0, ins(ADDI, 3'd3, 8'hFF));
    load(4'd1, ins(SHRI, 3'd3, 8'd9));
    load(4'd2, ins(HLT, 3'd0, 8'd0));
    run(50, cyc);
    peek(3'd3, v);
    chk("shr9_r3", {24'd0, v}, 32'd0);
    chk("shr9_flags", {29'd0, flags}, 32'b010);

    do_reset();
    load(4'd1, ins(SHRI, 3'd3, 8'd4));
    run(50, cyc);
    peek(3'd3, v);
    chk("shr4_r3", {24'd0, v}, 32'h0F);
    chk("shr4_flags", {29'd0, flags}, 32'b000);

    do_reset();
    load(4'd0, ins(ADDI, 3'd4, 8'd3));
    load(4'd1, ins(ADDI, 3'd5, 8'd5));
    load(4'd2, ins(SUB, 3'd4, 8'd5));
    load(4'd3, ins(JC, 3'd0, 8'd5));
    load(4'd4, ins(HLT, 3'd0, 8'd0));
    load(4'd5, ins(AND_, 3'd4, 8'd5));
    load(4'd6, ins(JN, 3'd0, 8'd8));
    load(4'd7, ins(HLT, 3'd0, 8'd0));
    run(50, cyc);
    peek(3'd4, v);
    chk("sub_and_r4", {24'd0, v}, 32'd4);
    chk("sub_and_pc", {28'd0, pc}, 32'd7);
    chk("sub_and_flags", {29'd0, flags}, 32'b000);

    do_reset();
    load(4'd0, ins(ADDI, 3'd6, 8'd1));
    for (int a = 1; a < 16; a++)
      load(4'(a), ins(NOP, 3'd0, 8'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("wrap_pc", {28'd0, pc}, 32'd0);
    peek(3'd6, v);
    chk("wrap_r6", {24'd0, v}, 32'd1);
    repeat (2) tick();
    peek(3'd6, v);
    chk("wrap2_r6", {24'd0, v}, 32'd2);
    chk("wrap2_pc", {28'd0, pc}, 32'd1);

    prog_we    = 1'b1;
    prog_addr  = 4'd0;
    prog_wdata = ins(HLT, 3'd0, 8'd0);
    start      = 1'b1;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    tick();
    chk("busy_pc", {28'd0, pc}, 32'd2);
    repeat (32) tick();
    chk("busy_halted", {31'd0, halted}, 32'd0);
    peek(3'd6, v);
    chk("busy_r6", {24'd0, v}, 32'd3);

    do_reset();
    load(4'd0, ins(ADDI, 3'd7, 8'd1));
    load(4'd1, ins(HLT, 3'd0, 8'd0));
    prog_we    = 1'b1;
    prog_addr  = 4'd0;
    prog_wdata = ins(ADDI, 3'd7, 8'd9);
    run(50, cyc);
    peek(3'd7, v);
    chk("same_cyc_r7", {24'd0, v}, 32'd9);
    chk("same_cyc_cycles", cyc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
Parametrised multicycle successor to the 4-bit CPU datapath. It bundles the instruction store, register file, ALU, flag register and PC behind an explicit HALT/FETCH/EXEC state machine, with a generic data width and register count. Host loads the program through a write port, pulses start, and observes state through a debug read port. Adds SUB, conditional jumps on Z/C/N, HALT, synchronous reset and an explicit run/halt handshake.

Parameters:
DATA_W, 8, datapath and register width (>=4)
NREG, 8, number of general registers (power of 2, >=2)
PM_DEPTH, 16, instruction words in program memory (power of 2)
Derived: RA_W=clog2(NREG), PC_W=clog2(PM_DEPTH), INSTR_W=4+RA_W+DATA_W (requires DATA_W>=RA_W and DATA_W>=PC_W)

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
prog_we  input  1  program-memory write strobe (honoured only in HALT)
prog_addr  input  PC_W  program write address
prog_wdata  input  INSTR_W  instruction word
start  input  1  one-cycle pulse: leave HALT, begin at pc=0
halted  output  1  1 while in HALT
pc  output  PC_W  current program counter
flags  output  3  {CF,ZF,SF} registered flags
dbg_raddr  input  RA_W  debug register select
dbg_rdata  output  DATA_W  combinational read of reg[dbg_raddr]
instr_cnt  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at edge): state=HALT, halted=1, pc=0, flags=0, ir=0, all registers=0, instr_cnt=0. Program memory is not cleared. Reset wins over every other input, mid-instruction included.
- Instruction fields: op=ir[INSTR_W-1 -:4], rd=next RA_W bits, low DATA_W bits = imm / rs (low RA_W bits) / jump target (low PC_W bits).
- Opcodes: 0000 ADD, 0001 AND, 0010 SHR, 0011 SUB: rd<=rd op rs. 0100-0111: same ops with imm as B. 1000 JMP, 1001 JZ, 1010 JC, 1011 JN. 1111 HALT. All others NOP.
- FSM: HALT -start-> FETCH (pc<=0). FETCH: ir<=pm[pc], go to EXEC. EXEC: execute, go to FETCH; HALT opcode goes to HALT with pc unchanged. Each instruction takes 2 cycles.
- start is ignored outside HALT. prog_we is ignored outside HALT.
- If prog_we and start arrive in the same HALT cycle, the write commits and the first FETCH sees the new word.
- ALU arithmetic is mod 2^DATA_W.
  - ADD: CF=carry out.
  - SUB: CF=1 iff A<B (unsigned borrow).
  - AND and SHR: CF=0.
  - SHR: logical shift; result=0 when B>=DATA_W.
  - ZF=(result==0), SF=result[DATA_W-1].
- Flags and rd are written only by ALU ops, in the EXEC edge. Jumps, NOP and HALT leave flags unchanged.
- Conditional jumps test the registered flags, i.e. the result of the previous ALU instruction.
- PC: taken jump sets pc=target; otherwise pc=pc+1, wrapping from PM_DEPTH-1 to 0.
- dbg_rdata reflects register contents after the edge (no bypass).

Optional Feature:
CPU_INSTR_CNT_EN
- Defined: instr_cnt increments by 1 at every EXEC edge, HALT opcode included; it wraps at 2^32 and clears on reset only.
- Undefined: no counter logic is built and instr_cnt is tied to 0.

Decomposition:
- Shared package cpu_core_pkg holds: opcode constants (OP_ADD … OP_HALT), FSM state enum (S_HALT, S_FETCH, S_EXEC), flag bit indices.
- One natural sub-module: cpu_alu_param (combinational, DATA_W-parametrised; outputs result, CF, ZF, SF).
- Register file, program memory and FSM stay in the top module.

Test Plan:
- Reset during a running program (DATA_W=8): halted=1, pc=0, flags=0, dbg_rdata=0 for every register; program memory contents retained.
- Load ADDI r1,200; ADDI r1,100; HALT; start: r1=44, CF=1, ZF=0, SF=0, halted after 6 cycles.
- Load ADDI r2,5; SUBI r2,5; JZ 5; …; @5 HALT: r2=0, ZF=1, pc=5 at halt, instr_cnt=4 with macro defined.
- SHRI r3 with imm 9 on r3=0xFF: r3=0, ZF=1, CF=0. SHRI with imm 4: r3=0x0F.
- Straight-line NOPs through address 15: pc wraps to 0 and execution continues.
- prog_we and start pulsed while running: memory word unchanged, pc unaffected. Same-cycle prog_we at addr 0 plus start in HALT: the new word executes first.
